// File: rtl/if_fetch.sv
// Small circular FIFO with synchronous flush, shared by the fetch address and instruction queues.
// Latency: a push is visible at dout the next cycle; dout is combinational from the head slot.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module if_fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] P_ONE = (AW+1)'(1);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + P_ONE;
            if (pop)  r_rptr <= r_rptr + P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rptr[AW-1:0]];
    assign count = r_wptr - r_rptr;
endmodule

// RV32I fetch initiator: credit-limited word requests, in-order capture, redirect with stale drop.
// Latency: first word reaches decode one cycle after its response (two after issue at memory latency 1).
// Backpressure: issue stalls while outstanding + buffered reaches DEPTH; decode stalls via inst_ready.
module if_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [63:0] order,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [63:0]   r_order;

    logic [CW-1:0] w_fifo_cnt;
    logic [CW-1:0] w_aq_cnt;
    logic [CW-1:0] w_out_next;
    logic [63:0]   w_head;
    logic [31:0]   w_resp_addr;
    logic [31:0]   w_redir_pc;
    logic          w_issue;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;

    // Credits count both in-flight requests and buffered words so a response always has a slot.
    assign w_issue    = !rst && !redirect_valid &&
                        (({1'b0, r_outstanding} + {1'b0, w_fifo_cnt}) < C_DEPTH);
    assign w_resp     = imem_resp && (r_outstanding != '0);
    assign w_push     = w_resp && !redirect_valid && (r_discard == '0);
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign w_redir_pc = redirect_pc & 32'hffff_fffc;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue) w_out_next = w_out_next + C_ONE;
        if (w_resp)  w_out_next = w_out_next - C_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_order       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_discard  <= w_out_next;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_resp && (r_discard != '0)) r_discard <= r_discard - C_ONE;
                if (w_pop) r_order <= r_order + 64'd1;
            end
        end
    end

    // Addresses of live (non-stale) requests, consumed as their responses are captured.
    if_fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_issue),
        .pop   (w_push),
        .din   (r_fetch_pc),
        .dout  (w_resp_addr),
        .count (w_aq_cnt)
    );

    if_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({imem_rdata, w_resp_addr}),
        .dout  (w_head),
        .count (w_fifo_cnt)
    );

    assign imem_addr  = r_fetch_pc;
    assign imem_rmask = {4{w_issue}};
    assign inst_valid = (w_fifo_cnt != '0);
    assign inst       = w_head[63:32];
    assign pc         = w_head[31:0];
    assign pc_next    = w_head[31:0] + 32'd4;
    assign order      = r_order;

`ifndef SYNTHESIS
    a_resp_legal: assert property (@(posedge clk) disable iff (rst)
        imem_resp |-> (r_outstanding != '0));
    a_addr_avail: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (w_aq_cnt != '0));
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: memory responder plus a queue-level model of the fetch stream.
module tb_if_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    if_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .pc_next        (pc_next),
        .order          (order),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          iss_cnt;
    int          n_chk;
    int          n_err;

    // Reference state: next fetch address, in-flight count, stale count, buffered PCs, live request PCs.
    logic [31:0] m_pc;
    int          m_out;
    int          m_disc;
    logic [31:0] m_fifo[$];
    logic [31:0] m_live[$];
    logic [63:0] m_order;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a3c_9613;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        mem_q.delete();
        m_fifo.delete();
        m_live.delete();
        m_pc    = RESET_PC;
        m_out   = 0;
        m_disc  = 0;
        m_order = '0;
        #2;
        check("rst_rmask", 64'(imem_rmask), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'(RESET_PC));
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_order", order, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
        logic        resp;
        logic        exp_issue;
        logic [31:0] e_next;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        resp           = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp      = resp;
        imem_rdata     = resp ? mem_word(mem_q[0].addr) : $urandom;
        #2;
        exp_issue = !redir && ((m_out + m_fifo.size()) < DEPTH);
        check("rmask", 64'(imem_rmask), exp_issue ? 64'hf : 64'h0);
        if (exp_issue) check("imem_addr", 64'(imem_addr), 64'(m_pc));
        check("inst_valid", 64'(inst_valid), 64'(m_fifo.size() > 0));
        check("order", order, m_order);
        if (m_fifo.size() > 0) begin
            e_next = m_fifo[0] + 32'd4;
            check("pc", 64'(pc), 64'(m_fifo[0]));
            check("pc_next", 64'(pc_next), 64'(e_next));
            check("inst", 64'(inst), 64'(mem_word(m_fifo[0])));
        end

        if (imem_rmask == 4'hf) begin
            iss_cnt++;
            mem_q.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
        end
        if (resp) void'(mem_q.pop_front());

        if (redir) begin
            if (resp) m_out--;
            m_disc = m_out;
            m_fifo.delete();
            m_live.delete();
            m_pc = rpc & 32'hffff_fffc;
        end else begin
            if ((m_fifo.size() > 0) && rdy) begin
                void'(m_fifo.pop_front());
                m_order++;
            end
            if (resp) begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else if (m_live.size() > 0) m_fifo.push_back(m_live.pop_front());
            end
            if (exp_issue) begin
                m_out++;
                m_live.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        cyc     = 0;
        iss_cnt = 0;
        lat_min = 1;
        lat_max = 1;

        do_reset();
        repeat (16) step(1'b0, '0, 1'b1);

        // Decode stalled: credits cap the requests at DEPTH, then drain.
        do_reset();
        iss_cnt = 0;
        repeat (10) step(1'b0, '0, 1'b0);
        check("stall_issues", 64'(iss_cnt), 64'(DEPTH));
        repeat (10) step(1'b0, '0, 1'b1);

        do_reset();
        lat_min = 3;
        lat_max = 3;
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h1eceb103, 1'b1);
        repeat (12) step(1'b0, '0, 1'b1);

        // Redirect colliding with a response and a handshake.
        lat_min = 1;
        lat_max = 1;
        repeat (6) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h1eceb200, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);

        lat_min = 3;
        lat_max = 3;
        repeat (4) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_4000, 1'b1);
        step(1'b1, 32'h0000_8000, 1'b1);
        repeat (12) step(1'b0, '0, 1'b1);

        lat_min = 1;
        lat_max = 1;
        step(1'b1, 32'hffff_fffc, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
